branch_unit: RTL

Parametrised branch resolution unit for the single-cycle core: holds the flag status register, resolves conditional branches against comparator outputs, and adds call/return support through a small circular return-address stack (RAS). It sits between the decoder/ALU compare outputs and the PC/fetch logic, supplying the next-PC override (`branch`, `address`) every cycle.

---
 rtl/branch_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/branch_unit.sv
// branch_unit: flag register, conditional branch resolution and a circular
// return-address stack for call/return. Supplies the next-PC override
// (branch/address) combinationally every cycle.
//
// Optional feature macro: BRANCH_FLAG_BYPASS_EN
//   When defined, a branch issued in the same cycle as a flag write resolves
//   against flag_in instead of the registered flags.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   cond            : compare-path conditions (cond[0]=less, cond[1]=equal)
//   w_flag, flag_in : flag register write enable / value
//   branch_instr    : conditional branch
//   call, ret       : call / return (priority ret > call > branch_instr)
//   immediate       : branch/call immediate, shifted left by SHIFT
//   pc_next         : return address pushed on call
//   address, branch : next-PC override
//   ras_full/empty  : stack occupancy status
//   ras_err         : sticky overflow/underflow flag
module branch_unit #(
  parameter int IMM_W     = 6,
  parameter int SHIFT     = 3,
  parameter int ADDR_W    = 9,
  parameter int FLAG_W    = 3,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLAG_W-2:0] cond,
  input  logic              w_flag,
  input  logic [FLAG_W-1:0] flag_in,
  input  logic              branch_instr,
  input  logic              call,
  input  logic              ret,
  input  logic [IMM_W-1:0]  immediate,
  input  logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] address,
  output logic              branch,
  output logic              ras_full,
  output logic              ras_empty,
  output logic              ras_err
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [FLAG_W-1:0]                 flag_q, flag_d;
  logic [PTR_W-1:0]                  wp_q, wp_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              err_q, err_d;
  logic [RAS_DEPTH-1:0][ADDR_W-1:0]  mem_q;
  logic                              push;
  logic [FLAG_W-1:0]                 flag_eff;
  logic                              take;
  logic [ADDR_W-1:0]                 target;
  logic [PTR_W-1:0]                  top_idx;

  assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
  assign ras_empty = (cnt_q == '0);
  assign ras_err   = err_q;
  assign target    = {immediate, {SHIFT{1'b0}}};
  assign top_idx   = wp_q - 1'b1;  // wraps modulo depth

`ifdef BRANCH_FLAG_BYPASS_EN
  assign flag_eff = (w_flag && branch_instr) ? flag_in : flag_q;
`else
  assign flag_eff = flag_q;
`endif

  always_comb begin
    take = flag_eff[0];
    for (int i = 1; i < FLAG_W; i++)
      take = take | (flag_eff[i] & cond[i-1]);
  end

  // Next-PC override
  always_comb begin
    branch  = 1'b0;
    address = target;
    if (reset) begin
      address = '0;
    end else if (ret) begin
      branch  = 1'b1;
      address = ras_empty ? '0 : mem_q[top_idx];  // underflow returns 0
    end else if (call) begin
      branch  = 1'b1;
    end else if (branch_instr) begin
      branch  = take;
    end
  end

  // Next-state for flags and stack bookkeeping
  always_comb begin
    flag_d = w_flag ? flag_in : flag_q;
    wp_d   = wp_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    push   = 1'b0;
    if (ret) begin
      if (ras_empty) begin
        err_d = 1'b1;
      end else begin
        wp_d  = wp_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
    end else if (call) begin
      // On overflow wp already points at the oldest entry, so the push
      // overwrites it while the count stays saturated.
      push = 1'b1;
      wp_d = wp_q + 1'b1;
      if (ras_full) err_d = 1'b1;
      else          cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flag_q <= '0;
      wp_q   <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      mem_q  <= '0;
    end else begin
      flag_q <= flag_d;
      wp_q   <= wp_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      if (push) mem_q[wp_q] <= pc_next;
    end
  end
endmodule
